// File: rtl/trk_pkg.sv
// trk_pkg: shared types and helpers for target_track_filter.
//   trk_state_e : tracker FSM states (SEARCH=0, ACQ=1, TRACK=2, COAST=3)
//   axis_op_e   : per-frame command from the FSM to each axis filter
//   center12    : box centre from two 12-bit edges, a/2 + b/2
//   clamp12     : clamp a 13-bit signed value into [0, max_v]
package trk_pkg;

  localparam int COORD_W = 12;
  localparam int ERR_W   = 13;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ACQ    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_COAST  = 2'd3
  } trk_state_e;

  // OP_COAST advances by the velocity; OP_LOST does the same and then
  // clears the velocity. Both reduce to a hold without velocity support.
  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_UPDATE = 3'd2,
    OP_COAST  = 3'd3,
    OP_LOST   = 3'd4
  } axis_op_e;

  // (a>>1)+(b>>1) is exactly a[11:1]+b[11:1]; max 2047+2047 fits 12 bits.
  function automatic logic [COORD_W-1:0] center12(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >> 1) + (b >> 1);
  endfunction

  function automatic logic [COORD_W-1:0] clamp12(input logic signed [ERR_W-1:0] v,
                                                 input logic [COORD_W-1:0]      max_v);
    if (v[ERR_W-1])                  return '0;
    else if (v[COORD_W-1:0] > max_v) return max_v;
    else                             return v[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/trk_axis_filter.sv
// trk_axis_filter: one axis (x or y) of the tracker's smoothed position.
//   clk, rst : clock, synchronous active-high reset
//   i_op     : command for this clock (OP_HOLD on all non-evaluation cycles)
//   i_meas   : measured centre coordinate
//   o_f      : filtered coordinate
//   o_abs_d  : |i_meas - o_f|, used by the FSM for the consistency test
// Optional macro TRK_VELOCITY_EN adds a clipped +/-31 px/frame velocity
// that is applied on each coasted frame.
module trk_axis_filter
  import trk_pkg::*;
#(
  parameter int LIMIT       = 1279,
  parameter int INIT        = 640,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  axis_op_e               i_op,
  input  logic [COORD_W-1:0]     i_meas,
  output logic [COORD_W-1:0]     o_f,
  output logic [ERR_W-1:0]       o_abs_d
);

  localparam logic [COORD_W-1:0] P_LIMIT = COORD_W'(LIMIT);
  localparam logic [COORD_W-1:0] P_INIT  = COORD_W'(INIT);

  logic [COORD_W-1:0]      r_f;
  logic [COORD_W-1:0]      w_f_nxt;
  logic signed [ERR_W-1:0] w_d;
  logic signed [ERR_W-1:0] w_step;
  logic signed [ERR_W-1:0] w_sum;

  assign w_d     = $signed({1'b0, i_meas}) - $signed({1'b0, r_f});
  // Arithmetic shift floors negative errors (toward -inf).
  assign w_step  = w_d >>> ALPHA_SHIFT;
  // f + floor(d/2^k) lies between f and meas, so 13 bits never overflow.
  assign w_sum   = $signed({1'b0, r_f}) + w_step;
  assign o_abs_d = w_d[ERR_W-1] ? -w_d : w_d;
  assign o_f     = r_f;

`ifdef TRK_VELOCITY_EN
  logic signed [5:0]       r_v;
  logic signed [5:0]       w_v_nxt;
  logic signed [5:0]       w_v_clip;
  logic signed [ERR_W-1:0] w_coast;

  always_comb begin
    if (w_d > 13'sd31)       w_v_clip = 6'sd31;
    else if (w_d < -13'sd31) w_v_clip = -6'sd31;
    else                     w_v_clip = w_d[5:0];
  end

  assign w_coast = $signed({1'b0, r_f}) + $signed({{7{r_v[5]}}, r_v});
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    w_f_nxt = r_f;
`ifdef TRK_VELOCITY_EN
    w_v_nxt = r_v;
`endif
    case (i_op)
      OP_LOAD:   w_f_nxt = clamp12($signed({1'b0, i_meas}), P_LIMIT);
      OP_UPDATE: begin
        w_f_nxt = clamp12(w_sum, P_LIMIT);
`ifdef TRK_VELOCITY_EN
        w_v_nxt = w_v_clip;
`endif
      end
`ifdef TRK_VELOCITY_EN
      OP_COAST:  w_f_nxt = clamp12(w_coast, P_LIMIT);
      OP_LOST: begin
        w_f_nxt = clamp12(w_coast, P_LIMIT);
        w_v_nxt = '0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_f <= P_INIT;
`ifdef TRK_VELOCITY_EN
      r_v <= '0;
`endif
    end else begin
      r_f <= w_f_nxt;
`ifdef TRK_VELOCITY_EN
      r_v <= w_v_nxt;
`endif
    end
  end

endmodule

// File: rtl/target_track_filter.sv
// target_track_filter: per-frame acquire/track/coast/lose tracker that
// smooths the judge stage's box centre and feeds it back as the next
// search centre.
//   clk, rst                 : pixel clock, synchronous active-high reset
//   per_frame_vsync          : rising edge = frame start (tick at cycle T)
//   det_en, det_top/down/left/right : detection, captured at T+1
//   trk_valid                : TRACK or COAST
//   trk_xy                   : {x[23:12], y[11:0]} filtered centre
//   trk_state                : SEARCH=0, ACQ=1, TRACK=2, COAST=3
//   miss_cnt                 : consecutive misses while coasting
// Outputs update on the edge ending T+2.
// Optional macro TRK_VELOCITY_EN: velocity extrapolation while coasting.
module target_track_filter
  import trk_pkg::*;
#(
  parameter int IMG_HDISP   = 1280,
  parameter int IMG_VDISP   = 720,
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 8,
  parameter int ALPHA_SHIFT = 2,
  parameter int JUMP_MAX    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        det_en,
  input  logic [11:0] det_top,
  input  logic [11:0] det_down,
  input  logic [11:0] det_left,
  input  logic [11:0] det_right,
  output logic        trk_valid,
  output logic [23:0] trk_xy,
  output logic [1:0]  trk_state,
  output logic [3:0]  miss_cnt
);

  localparam logic [3:0]       P_ACQ  = 4'(ACQ_FRAMES);
  localparam logic [3:0]       P_LOST = 4'(LOST_FRAMES);
  localparam logic [ERR_W-1:0] P_JUMP = ERR_W'(JUMP_MAX);

  logic               r_vsync;
  logic               r_armed;
  logic               r_cap_pend;
  logic               r_eval_pend;
  logic               r_det_en;
  logic [11:0]        r_det_top, r_det_down, r_det_left, r_det_right;
  trk_state_e         r_state;
  logic [3:0]         r_acq_cnt;
  logic [3:0]         r_miss_cnt;

  logic               w_tick;
  logic               w_hit;
  logic               w_near;
  logic [COORD_W-1:0] w_cx, w_cy, w_fx, w_fy;
  logic [ERR_W-1:0]   w_abs_dx, w_abs_dy;
  logic [3:0]         w_acq_inc, w_miss_inc;
  trk_state_e         w_state_nxt;
  logic [3:0]         w_acq_nxt, w_miss_nxt;
  axis_op_e           w_op, w_op_q;

  // r_armed stays low until vsync has been seen low after reset, so a
  // vsync already high at reset release never looks like a rising edge.
  assign w_tick = per_frame_vsync & ~r_vsync & r_armed;

  assign w_cx  = center12(r_det_left, r_det_right);
  assign w_cy  = center12(r_det_top, r_det_down);
  assign w_hit = r_det_en & (r_det_left <= r_det_right) & (r_det_top <= r_det_down);
  assign w_near = w_hit & (w_abs_dx <= P_JUMP) & (w_abs_dy <= P_JUMP);

  assign w_acq_inc  = r_acq_cnt + 4'd1;
  assign w_miss_inc = r_miss_cnt + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_acq_nxt   = r_acq_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_op        = OP_HOLD;
    case (r_state)
      ST_SEARCH: if (w_hit) begin
        w_state_nxt = ST_ACQ;
        w_acq_nxt   = 4'd1;
        w_op        = OP_LOAD;
      end
      ST_ACQ: begin
        if (w_near) begin
          w_op      = OP_LOAD;
          w_acq_nxt = w_acq_inc;
          if (w_acq_inc >= P_ACQ) w_state_nxt = ST_TRACK;
        end else if (w_hit) begin
          w_op      = OP_LOAD;
          w_acq_nxt = 4'd1;
        end else begin
          w_state_nxt = ST_SEARCH;
          w_acq_nxt   = 4'd0;
          w_op        = OP_LOST;
        end
      end
      ST_TRACK: begin
        if (w_near) begin
          w_op = OP_UPDATE;
        end else begin
          w_state_nxt = ST_COAST;
          w_miss_nxt  = 4'd1;
        end
      end
      ST_COAST: begin
        if (w_near) begin
          w_state_nxt = ST_TRACK;
          w_miss_nxt  = 4'd0;
          w_op        = OP_UPDATE;
        end else if (w_miss_inc >= P_LOST) begin
          w_state_nxt = ST_SEARCH;
          w_miss_nxt  = 4'd0;
          w_acq_nxt   = 4'd0;
          w_op        = OP_LOST;
        end else begin
          w_miss_nxt  = w_miss_inc;
          w_op        = OP_COAST;
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  // Filters only move on the evaluation cycle (T+2).
  assign w_op_q = r_eval_pend ? w_op : OP_HOLD;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync     <= 1'b0;
      r_armed     <= 1'b0;
      r_cap_pend  <= 1'b0;
      r_eval_pend <= 1'b0;
      r_det_en    <= 1'b0;
      r_det_top   <= '0;
      r_det_down  <= '0;
      r_det_left  <= '0;
      r_det_right <= '0;
      r_state     <= ST_SEARCH;
      r_acq_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_vsync     <= per_frame_vsync;
      r_armed     <= r_armed | ~per_frame_vsync;
      r_cap_pend  <= w_tick;
      // A new tick restarts the pipeline and drops any pending evaluation.
      r_eval_pend <= r_cap_pend & ~w_tick;
      if (r_cap_pend) begin
        r_det_en    <= det_en;
        r_det_top   <= det_top;
        r_det_down  <= det_down;
        r_det_left  <= det_left;
        r_det_right <= det_right;
      end
      if (r_eval_pend) begin
        r_state    <= w_state_nxt;
        r_acq_cnt  <= w_acq_nxt;
        r_miss_cnt <= w_miss_nxt;
      end
    end
  end

  trk_axis_filter #(
    .LIMIT(IMG_HDISP - 1), .INIT(IMG_HDISP / 2), .ALPHA_SHIFT(ALPHA_SHIFT)
  ) u_x (
    .clk(clk), .rst(rst), .i_op(w_op_q), .i_meas(w_cx),
    .o_f(w_fx), .o_abs_d(w_abs_dx)
  );

  trk_axis_filter #(
    .LIMIT(IMG_VDISP - 1), .INIT(IMG_VDISP / 2), .ALPHA_SHIFT(ALPHA_SHIFT)
  ) u_y (
    .clk(clk), .rst(rst), .i_op(w_op_q), .i_meas(w_cy),
    .o_f(w_fy), .o_abs_d(w_abs_dy)
  );

  assign trk_state = r_state;
  assign trk_valid = (r_state == ST_TRACK) || (r_state == ST_COAST);
  assign trk_xy    = {w_fx, w_fy};
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_target_track_filter.sv
// tb_target_track_filter: directed-vector bench for target_track_filter at
// default parameters. Expected values are hand-computed constants.
module tb_target_track_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        per_frame_vsync;
  logic        det_en;
  logic [11:0] det_top, det_down, det_left, det_right;
  logic        trk_valid;
  logic [23:0] trk_xy;
  logic [1:0]  trk_state;
  logic [3:0]  miss_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  target_track_filter dut (
    .clk(clk), .rst(rst), .per_frame_vsync(per_frame_vsync),
    .det_en(det_en), .det_top(det_top), .det_down(det_down),
    .det_left(det_left), .det_right(det_right),
    .trk_valid(trk_valid), .trk_xy(trk_xy), .trk_state(trk_state),
    .miss_cnt(miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    else
      n_pass++;
  endtask

  task automatic set_det(input logic en, input logic [11:0] l, r, t, d);
    det_en = en; det_left = l; det_right = r; det_top = t; det_down = d;
  endtask

  // One frame: vsync high for 3 cycles, low for 4; ends on a negedge with
  // the frame's update (edge ending T+2) already applied.
  task automatic send_frame(input logic en, input logic [11:0] l, r, t, d);
    @(negedge clk);
    set_det(en, l, r, t, d);
    per_frame_vsync = 1'b1;
    repeat (3) @(negedge clk);
    per_frame_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [1:0] st, input logic [11:0] x,
                           input logic [11:0] y, input logic [3:0] mc);
    check({tag, "_state"}, trk_state, st);
    check({tag, "_xy"},    trk_xy,    {x, y});
    check({tag, "_valid"}, trk_valid, (st == 2'd2) || (st == 2'd3));
    check({tag, "_miss"},  miss_cnt,  mc);
  endtask

  initial begin
    rst = 1'b1;
    per_frame_vsync = 1'b0;
    set_det(1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_out("reset", 2'd0, 12'd640, 12'd360, 4'd0);

    // No detections: stays in SEARCH at the image centre.
    for (int i = 0; i < 5; i++) begin
      send_frame(1'b0, 12'd600, 12'd620, 12'd300, 12'd320);
      check_out("idle", 2'd0, 12'd640, 12'd360, 4'd0);
    end

    // Acquire centre (610,310).
    send_frame(1'b1, 12'd600, 12'd620, 12'd300, 12'd320);
    check_out("acq1", 2'd1, 12'd610, 12'd310, 4'd0);
    send_frame(1'b1, 12'd600, 12'd620, 12'd300, 12'd320);
    check_out("acq2", 2'd1, 12'd610, 12'd310, 4'd0);

    // Third frame inline to check the T+2 update latency.
    @(negedge clk);
    per_frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_pre_valid", trk_valid, 1'b0);
    check("lat_pre_state", trk_state, 2'd1);
    @(negedge clk);
    check("lat_post_valid", trk_valid, 1'b1);
    check("lat_post_state", trk_state, 2'd2);
    per_frame_vsync = 1'b0;
    repeat (4) @(negedge clk);
    check_out("track", 2'd2, 12'd610, 12'd310, 4'd0);

    // Centre (650,310): dx=40 -> x += 10.
    send_frame(1'b1, 12'd640, 12'd660, 12'd300, 12'd320);
    check_out("smooth", 2'd2, 12'd620, 12'd310, 4'd0);

    // Centre (1000,310) too far -> COAST, position held.
    send_frame(1'b1, 12'd990, 12'd1010, 12'd300, 12'd320);
    check_out("jump", 2'd3, 12'd620, 12'd310, 4'd1);

    // Misses 2..7 stay in COAST; the 8th returns to SEARCH.
    for (int k = 2; k <= 7; k++) begin
      send_frame(1'b0, 12'd600, 12'd620, 12'd300, 12'd320);
      check("coast_state", trk_state, 2'd3);
      check("coast_miss", miss_cnt, 4'(k));
    end
    send_frame(1'b0, 12'd600, 12'd620, 12'd300, 12'd320);
    check_out("lost", 2'd0, 12'd620, 12'd310, 4'd0);

    // Acquire at x=1275, then centre 1339 (dx=64, still near):
    // 1275 + 16 = 1291 clamps to 1279.
    for (int i = 0; i < 3; i++)
      send_frame(1'b1, 12'd1274, 12'd1276, 12'd300, 12'd320);
    check_out("edge_trk", 2'd2, 12'd1275, 12'd310, 4'd0);
    send_frame(1'b1, 12'd1338, 12'd1340, 12'd300, 12'd320);
    check_out("clamp", 2'd2, 12'd1279, 12'd310, 4'd0);

    // Inverted box with det_en=1 is a miss.
    send_frame(1'b1, 12'd1290, 12'd1270, 12'd300, 12'd320);
    check_out("badbox", 2'd3, 12'd1279, 12'd310, 4'd1);

    // Recover with centre 1264: dx=-15, floor(-15/4)=-4 -> 1275.
    send_frame(1'b1, 12'd1264, 12'd1264, 12'd300, 12'd320);
    check_out("recover", 2'd2, 12'd1275, 12'd310, 4'd0);

    // Reset while an evaluation is pending, vsync held high across release.
    @(negedge clk);
    set_det(1'b1, 12'd1274, 12'd1276, 12'd300, 12'd320);
    per_frame_vsync = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_out("midrst", 2'd0, 12'd640, 12'd360, 4'd0);
    repeat (6) @(negedge clk);
    check_out("vs_high", 2'd0, 12'd640, 12'd360, 4'd0);
    per_frame_vsync = 1'b0;
    repeat (4) @(negedge clk);

    // ACQ: inconsistent hit reloads, then no hit returns to SEARCH holding f.
    send_frame(1'b1, 12'd90, 12'd110, 12'd90, 12'd110);
    check_out("acq_a", 2'd1, 12'd100, 12'd100, 4'd0);
    send_frame(1'b1, 12'd490, 12'd510, 12'd90, 12'd110);
    check_out("acq_jump", 2'd1, 12'd500, 12'd100, 4'd0);
    send_frame(1'b0, 12'd490, 12'd510, 12'd90, 12'd110);
    check_out("acq_drop", 2'd0, 12'd500, 12'd100, 4'd0);

`ifdef TRK_VELOCITY_EN
    // Track at 100, then measurement 108: f=102, v=+8; coast by v.
    for (int i = 0; i < 3; i++)
      send_frame(1'b1, 12'd90, 12'd110, 12'd90, 12'd110);
    send_frame(1'b1, 12'd98, 12'd118, 12'd90, 12'd110);
    check_out("vel_trk", 2'd2, 12'd102, 12'd100, 4'd0);
    send_frame(1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
    check_out("vel_c1", 2'd3, 12'd102, 12'd100, 4'd1);
    send_frame(1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
    check_out("vel_c2", 2'd3, 12'd110, 12'd100, 4'd2);
    send_frame(1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
    check_out("vel_c3", 2'd3, 12'd118, 12'd100, 4'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
